// File: rtl/nbcac_pkg.sv
// rtl/nbcac_pkg.sv - shared NBCAC widths, types and the buffered receive word layout
package nbcac_pkg;

   localparam int NBCAC_DATA_W = 8;
   localparam int NBCAC_CODE_W = 11;

   typedef logic [NBCAC_DATA_W-1:0] nbcac_data_t;
   // Codewords keep the bus numbering, bit 1 is the lowest wire
   typedef logic [NBCAC_CODE_W:1]   nbcac_code_t;

   // One buffered receive entry: illegal flag above the decoded byte
   typedef struct packed {
      logic        err;
      nbcac_data_t data;
   } nbcac_rx_word_t;

   localparam int NBCAC_RX_WORD_W = $bits(nbcac_rx_word_t);

endpackage

// File: rtl/nbcac_8di_decoder_core.sv
// rtl/nbcac_8di_decoder_core.sv - 11-bit NBCAC codeword to 8-bit data (combinational)
module nbcac_8di_decoder_core
   import nbcac_pkg::*;
(
   input  nbcac_code_t d,
   output nbcac_data_t v
);

   // Take one copy of every duplicated bit; consistency of the other copy is
   // judged by the caller through re-encoding
   assign v = {d[11:9], d[7:6], d[4:3], d[1]};

endmodule

// File: rtl/nbcac_8di_encoder_core.sv
// rtl/nbcac_8di_encoder_core.sv - 8-bit to 11-bit NBCAC encoder (combinational)
module nbcac_8di_encoder_core
   import nbcac_pkg::*;
(
   input  nbcac_data_t v,
   output nbcac_code_t d
);

   // Bits 5, 3 and 1 are each driven on two adjacent wires, so the wires at
   // the group boundaries always move together and never switch opposite to
   // their neighbour: d = v7 v6 v5 v5 v4 v3 v3 v2 v1 v1 v0
   assign d = {v[7:5], v[5:3], v[3:1], v[1:0]};

endmodule

// File: rtl/nbcac_rx_fifo.sv
// rtl/nbcac_rx_fifo.sv - first-word-fall-through FIFO with accept-on-full-when-popping
module nbcac_rx_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     rst_n,
   input  logic                     wr_valid,
   input  logic [WIDTH-1:0]         wr_data,
   output logic                     wr_accept,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             empty;
   logic             full;
   logic             pop;

   // Extra pointer MSB tells a full buffer from an empty one
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop       = rd_valid & rd_ready;
   assign wr_accept = wr_valid & (~full | pop);
   assign rd_valid  = ~empty;
   // Head is forced to zero when empty so stale entries never show
   assign rd_data   = empty ? '0 : mem[rd_ptr[AW-1:0]];
   assign level     = wr_ptr - rd_ptr;

   // Pointer advance on accepted write and on pop
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_accept) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)       rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage write; contents are only visible through the gated head
   always_ff @(posedge clock) begin
      if (wr_accept) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/nbcac_rx_decoder_11.sv
// rtl/nbcac_rx_decoder_11.sv - registered NBCAC receive decoder with illegal-word flag and output FIFO
module nbcac_rx_decoder_11
   import nbcac_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int ERRCNT_W   = 16
) (
   input  logic                          clock,
   input  logic                          rst_n,
   input  nbcac_code_t                   codein,
   input  logic                          codein_valid,
   output nbcac_data_t                   dataout,
   output logic                          dataout_err,
   output logic                          dataout_valid,
   input  logic                          dataout_ready,
   output logic [ERRCNT_W-1:0]           err_count,
   output logic                          overflow,
   input  logic                          err_clr,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   nbcac_code_t    s1_code;
   logic           s1_valid;
   nbcac_data_t    dec;
   nbcac_code_t    reenc;
   logic           illegal;
   nbcac_data_t    s2_data;
   logic           s2_err;
   logic           s2_valid;
   nbcac_rx_word_t wr_word;
   nbcac_rx_word_t rd_word;
   logic           wr_accept;
   logic           drop;

   // Bus capture: nothing downstream sees codein combinationally
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         s1_code  <= '0;
         s1_valid <= 1'b0;
      end else begin
         s1_code  <= codein;
         s1_valid <= codein_valid;
      end
   end

   nbcac_8di_decoder_core u_dec (
      .d (s1_code),
      .v (dec)
   );

   // A word is legal only if decoding then encoding reproduces it exactly
   nbcac_8di_encoder_core u_reenc (
      .v (dec),
      .d (reenc)
   );

   assign illegal = (reenc != s1_code);

   // Decode stage register; illegal words keep their raw decode
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         s2_data  <= '0;
         s2_err   <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         s2_data  <= dec;
         s2_err   <= illegal;
         s2_valid <= s1_valid;
      end
   end

   assign wr_word.err  = s2_err;
   assign wr_word.data = s2_data;

   nbcac_rx_fifo #(
      .WIDTH (NBCAC_RX_WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .rst_n     (rst_n),
      .wr_valid  (s2_valid),
      .wr_data   (wr_word),
      .wr_accept (wr_accept),
      .rd_data   (rd_word),
      .rd_valid  (dataout_valid),
      .rd_ready  (dataout_ready),
      .level     (fifo_level)
   );

   assign dataout     = rd_word.data;
   assign dataout_err = rd_word.err;
   assign drop        = s2_valid & ~wr_accept;

   // Saturating illegal-word count and sticky drop flag; clear wins over both
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
         overflow  <= 1'b0;
      end else if (err_clr) begin
         err_count <= '0;
         overflow  <= 1'b0;
      end else begin
         if (s2_valid && s2_err && (err_count != {ERRCNT_W{1'b1}}))
            err_count <= err_count + ERRCNT_W'(1);
         if (drop)
            overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_nbcac_rx_decoder_11.sv
// tb/tb_nbcac_rx_decoder_11.sv - scoreboard bench for nbcac_rx_decoder_11
module tb_nbcac_rx_decoder_11;

   logic         clock = 1'b0;
   logic         rst_n;
   logic [11:1]  codein;
   logic         codein_valid;
   logic [7:0]   dataout;
   logic         dataout_err;
   logic         dataout_valid;
   logic         dataout_ready;
   logic [15:0]  err_count;
   logic         overflow;
   logic         err_clr;
   logic [2:0]   fifo_level;

   typedef struct {
      logic [8:0] exp;
      bit         data_chk;
   } sb_t;

   sb_t         sb[$];
   sb_t         head;
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   bit          mark_first = 0;
   int          first_pop_cyc = 0;
   int          last_pop_cyc = 0;
   bit          legal_map [0:2047];
   logic [10:0] illegal[$];
   logic [10:0] ill0, ill1, ill2;

   nbcac_rx_decoder_11 dut (
      .clock         (clock),
      .rst_n         (rst_n),
      .codein        (codein),
      .codein_valid  (codein_valid),
      .dataout       (dataout),
      .dataout_err   (dataout_err),
      .dataout_valid (dataout_valid),
      .dataout_ready (dataout_ready),
      .err_count     (err_count),
      .overflow      (overflow),
      .err_clr       (err_clr),
      .fifo_level    (fifo_level)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [10:0] enc_m(input logic [7:0] x);
      return {x[7], x[6], x[5], x[5], x[4], x[3], x[3], x[2], x[1], x[1], x[0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] d, input logic err, input bit chk);
      sb_t e;
      e.exp      = {err, d};
      e.data_chk = chk;
      sb.push_back(e);
   endtask

   task automatic drive_word(input logic [10:0] c);
      @(posedge clock);
      #1;
      codein       = c;
      codein_valid = 1'b1;
   endtask

   task automatic idle();
      @(posedge clock);
      #1;
      codein_valid = 1'b0;
      codein       = '0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((sb.size() != 0 || dataout_valid) && n < budget) begin
         @(negedge clock);
         n++;
      end
      check("drain_done", {31'd0, (sb.size() == 0 && !dataout_valid)}, 32'd1);
   endtask

   task automatic pulse_clr();
      @(posedge clock);
      #1;
      err_clr = 1'b1;
      @(posedge clock);
      #1;
      err_clr = 1'b0;
   endtask

   // Pops are compared at the falling edge, before the rising edge that consumes them
   always @(negedge clock) begin
      if (rst_n && dataout_valid && dataout_ready) begin
         if (sb.size() == 0) begin
            check("pop_without_expected", 32'(sb.size()), 32'd1);
         end else begin
            head = sb.pop_front();
            if (head.data_chk)
               check("head_word", {23'd0, dataout_err, dataout}, {23'd0, head.exp});
            else
               check("head_err_flag", {31'd0, dataout_err}, {31'd0, head.exp[8]});
            last_pop_cyc = cyc;
            if (mark_first) begin
               first_pop_cyc = cyc;
               mark_first    = 0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      codein        = '0;
      codein_valid  = 1'b0;
      dataout_ready = 1'b1;
      err_clr       = 1'b0;

      for (int c = 0; c < 2048; c++) legal_map[c] = 1'b0;
      for (int x = 0; x < 256; x++) legal_map[enc_m(8'(x))] = 1'b1;
      for (int c = 0; c < 2048; c++) if (!legal_map[c]) illegal.push_back(11'(c));
      ill0 = illegal[0];
      ill1 = illegal[illegal.size() / 2];
      ill2 = illegal[illegal.size() - 1];

      // reset state
      #12;
      check("reset_valid", {31'd0, dataout_valid}, 32'd0);
      check("reset_data", {24'd0, dataout}, 32'd0);
      check("reset_level", {29'd0, fifo_level}, 32'd0);
      check("reset_errcnt", {16'd0, err_count}, 32'd0);
      check("reset_overflow", {31'd0, overflow}, 32'd0);
      @(posedge clock);
      #1;
      rst_n = 1'b1;

      // single word, latency and one-cycle presence
      drive_word(enc_m(8'hA5));
      push_exp(8'hA5, 1'b0, 1'b1);
      idle();
      @(negedge clock);
      check("single_valid_n", {31'd0, dataout_valid}, 32'd0);
      @(negedge clock);
      check("single_valid_n1", {31'd0, dataout_valid}, 32'd0);
      @(negedge clock);
      check("single_valid_n2", {31'd0, dataout_valid}, 32'd1);
      @(negedge clock);
      check("single_valid_n3", {31'd0, dataout_valid}, 32'd0);
      check("single_errcnt", {16'd0, err_count}, 32'd0);

      // exhaustive legal stream, no bubbles
      mark_first = 1;
      for (int i = 0; i < 256; i++) begin
         drive_word(enc_m(8'(i)));
         push_exp(8'(i), 1'b0, 1'b1);
      end
      idle();
      drain(50);
      check("stream_span", 32'(last_pop_cyc - first_pop_cyc), 32'd255);
      check("stream_errcnt", {16'd0, err_count}, 32'd0);

      // illegal words interleaved with a legal one
      drive_word(ill0);          push_exp(8'h00, 1'b1, 1'b0);
      drive_word(enc_m(8'h3C));  push_exp(8'h3C, 1'b0, 1'b1);
      drive_word(ill1);          push_exp(8'h00, 1'b1, 1'b0);
      drive_word(enc_m(8'h3C));  push_exp(8'h3C, 1'b0, 1'b1);
      drive_word(ill2);          push_exp(8'h00, 1'b1, 1'b0);
      idle();
      drain(20);
      check("illegal_errcnt", {16'd0, err_count}, 32'd3);
      pulse_clr();
      @(negedge clock);
      check("errcnt_cleared", {16'd0, err_count}, 32'd0);

      // clear on the same edge as an illegal write wins
      drive_word(ill1);
      push_exp(8'h00, 1'b1, 1'b0);
      idle();
      pulse_clr();
      @(negedge clock);
      check("clr_priority_errcnt", {16'd0, err_count}, 32'd0);
      drain(20);

      // overflow with consumer stalled
      @(posedge clock);
      #1;
      dataout_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive_word(enc_m(8'h40 + 8'(i)));
         if (i < 4) push_exp(8'h40 + 8'(i), 1'b0, 1'b1);
      end
      idle();
      repeat (3) @(negedge clock);
      check("ovf_level", {29'd0, fifo_level}, 32'd4);
      check("ovf_flag", {31'd0, overflow}, 32'd1);
      check("ovf_head_stable", {23'd0, dataout_err, dataout}, 32'h040);
      @(posedge clock);
      #1;
      dataout_ready = 1'b1;
      drain(20);
      check("ovf_drained_level", {29'd0, fifo_level}, 32'd0);
      pulse_clr();
      @(negedge clock);
      check("ovf_cleared", {31'd0, overflow}, 32'd0);

      // full buffer with push and pop on the same edge
      @(posedge clock);
      #1;
      dataout_ready = 1'b0;
      for (int i = 0; i < 14; i++) begin
         @(posedge clock);
         #1;
         codein       = enc_m(8'h80 + 8'(i));
         codein_valid = 1'b1;
         if (i == 6) dataout_ready = 1'b1;
         push_exp(8'h80 + 8'(i), 1'b0, 1'b1);
         @(negedge clock);
         if (i >= 6) check("full_pushpop_level", {29'd0, fifo_level}, 32'd4);
      end
      idle();
      drain(20);
      check("full_pushpop_overflow", {31'd0, overflow}, 32'd0);

      // reset mid-stream: two buffered, two in the pipeline
      @(posedge clock);
      #1;
      dataout_ready = 1'b0;
      drive_word(ill0);
      drive_word(enc_m(8'h01));
      drive_word(enc_m(8'h02));
      drive_word(enc_m(8'h03));
      idle();
      #2;
      check("pre_rst_level", {29'd0, fifo_level}, 32'd2);
      check("pre_rst_errcnt", {16'd0, err_count}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, dataout_valid}, 32'd0);
      check("mid_rst_word", {23'd0, dataout_err, dataout}, 32'd0);
      check("mid_rst_level", {29'd0, fifo_level}, 32'd0);
      check("mid_rst_errcnt", {16'd0, err_count}, 32'd0);
      check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
      sb.delete();
      @(posedge clock);
      @(posedge clock);
      #3;
      rst_n         = 1'b1;
      dataout_ready = 1'b1;
      drive_word(enc_m(8'h5A));
      push_exp(8'h5A, 1'b0, 1'b1);
      idle();
      @(negedge clock);
      check("post_rst_valid_n", {31'd0, dataout_valid}, 32'd0);
      @(negedge clock);
      check("post_rst_valid_n1", {31'd0, dataout_valid}, 32'd0);
      @(negedge clock);
      check("post_rst_valid_n2", {31'd0, dataout_valid}, 32'd1);
      drain(10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
